// File: rtl/if_id_pipe_pkg.sv
// Shared definitions for the IF/ID boundary register: reset polarity, bus
// widths, the zero word and the bubble encoding.
package if_id_pipe_pkg;

  localparam logic        RST_ENABLE      = 1'b1;
  localparam int          INST_ADDR_BUS_W = 32;
  localparam int          INST_BUS_W      = 32;
  localparam logic [31:0] ZERO_WORD       = 32'h0000_0000;
  localparam logic [31:0] NOP_ENCODING    = 32'h0000_0000;

  function automatic logic beat_xfer(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/if_id_pipe.sv
// IF/ID boundary register with valid/ready handshake, flush and a one-entry
// skid buffer so that if_ready is a flop and never a combinational path from id_ready.
module if_id_pipe
  import if_id_pipe_pkg::*;
#(
  parameter int                 ADDR_W   = INST_ADDR_BUS_W,
  parameter int                 INST_W   = INST_BUS_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(ZERO_WORD),
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_ENCODING)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [ADDR_W-1:0] if_pc,
  input  logic [INST_W-1:0] if_inst,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0] id_inst,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic              id_valid_q, id_valid_d;
  logic              if_ready_q, if_ready_d;
  logic [1:0]        occupancy_q, occupancy_d;
  logic              up_xfer_s, dn_xfer_s;

  assign up_xfer_s = beat_xfer(if_valid, if_ready_q);
  assign dn_xfer_s = beat_xfer(id_valid_q, id_ready);

  // Next state and slot contents; the main slot holds the bubble whenever it is empty
  always_comb begin
    state_d     = state_q;
    main_pc_d   = main_pc_q;
    main_inst_d = main_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    if (flush) begin
      state_d     = ST_EMPTY;
      main_inst_d = NOP_INST;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_xfer_s) begin
            state_d     = ST_BUSY;
            main_pc_d   = if_pc;
            main_inst_d = if_inst;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (up_xfer_s && dn_xfer_s) begin
            main_pc_d   = if_pc;
            main_inst_d = if_inst;
          end else if (up_xfer_s) begin
            state_d     = ST_FULL;
            skid_pc_d   = if_pc;
            skid_inst_d = if_inst;
          end else if (dn_xfer_s) begin
            state_d     = ST_EMPTY;
            main_inst_d = NOP_INST;
          end else begin
            state_d = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (dn_xfer_s) begin
            state_d     = ST_BUSY;
            main_pc_d   = skid_pc_q;
            main_inst_d = skid_inst_q;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          main_inst_d = NOP_INST;
        end
      endcase
    end
  end

  // Handshake and occupancy outputs decoded from the next state so they leave flops
  always_comb begin
    id_valid_d  = 1'b0;
    if_ready_d  = 1'b1;
    occupancy_d = 2'd0;
    case (state_d)
      ST_EMPTY: begin
        id_valid_d  = 1'b0;
        if_ready_d  = 1'b1;
        occupancy_d = 2'd0;
      end
      ST_BUSY: begin
        id_valid_d  = 1'b1;
        if_ready_d  = 1'b1;
        occupancy_d = 2'd1;
      end
      ST_FULL: begin
        id_valid_d  = 1'b1;
        if_ready_d  = 1'b0;
        occupancy_d = 2'd2;
      end
      default: begin
        id_valid_d  = 1'b0;
        if_ready_d  = 1'b1;
        occupancy_d = 2'd0;
      end
    endcase
  end

  // State, slot and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q     <= ST_EMPTY;
      main_pc_q   <= RESET_PC;
      main_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
      skid_inst_q <= '0;
      id_valid_q  <= 1'b0;
      if_ready_q  <= 1'b1;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_pc_q   <= main_pc_d;
      main_inst_q <= main_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
      id_valid_q  <= id_valid_d;
      if_ready_q  <= if_ready_d;
      occupancy_q <= occupancy_d;
    end
  end

  assign if_ready  = if_ready_q;
  assign id_valid  = id_valid_q;
  assign id_pc     = main_pc_q;
  assign id_inst   = main_inst_q;
  assign occupancy = occupancy_q;

endmodule

// File: doc/if_id_pipe.md
Name: if_id_pipe

Overview:
Next-generation IF/ID boundary register with parametrised widths, valid/ready handshaking, flush and a one-entry skid buffer. It sits between the fetch and decode stages. Fetch can therefore be stalled by decode back-pressure without a combinational ready path from decode to fetch. Flushed or empty slots present a bubble instruction to decode.

Parameters:
ADDR_W, 32, width of the PC field
INST_W, 32, width of the instruction field
RESET_PC, 32'h0000_0000, value driven on id_pc at reset
NOP_INST, 32'h0000_0000, bubble instruction driven on id_inst whenever id_valid=0

Ports:
clk  in  1  stage clock; all state updates on the rising edge
rst  in  1  reset; asynchronous assert, active-high
flush  in  1  discard all buffered and incoming beats (branch mispredict or exception)
if_valid  in  1  fetch presents a beat
if_ready  out  1  register can accept a beat; a registered output that never depends combinationally on id_ready
if_pc  in  ADDR_W  fetch PC
if_inst  in  INST_W  fetched instruction
id_valid  out  1  decode beat valid
id_ready  in  1  decode accepts the beat
id_pc  out  ADDR_W  PC to decode
id_inst  out  INST_W  instruction to decode; equals NOP_INST when id_valid=0
occupancy  out  2  number of buffered beats, 0..2

Behaviour:
- Reset (async, rst=1): state=EMPTY; id_valid=0, id_pc=RESET_PC, id_inst=NOP_INST, if_ready=1, occupancy=0. Skid contents are don't-care.
- Accept: up_xfer = if_valid & if_ready. Deliver: dn_xfer = id_valid & id_ready.
- Storage: a main slot drives the id_* outputs; a skid slot sits behind it.
- State machine:
  - EMPTY, occupancy 0:
    - up_xfer -> BUSY; main <= {if_pc, if_inst}.
    - Otherwise stay in EMPTY.
  - BUSY, occupancy 1:
    - up_xfer & dn_xfer -> BUSY; main <= incoming beat.
    - up_xfer only -> FULL; skid <= incoming beat.
    - dn_xfer only -> EMPTY.
    - Neither -> hold.
  - FULL, occupancy 2 (if_ready=0):
    - dn_xfer -> BUSY; main <= skid.
    - Otherwise hold.
- if_ready = (state != FULL), registered from the next state.
- Latency: 1 cycle from if_valid/if_ready to id_valid when EMPTY. Sustained throughput is 1 beat/cycle while id_ready=1.
- Ordering: beats are delivered strictly in acceptance order. No duplication, no loss except by flush.
- Flush has priority over everything:
  - Next state is EMPTY; id_valid=0 and id_inst=NOP_INST next cycle.
  - A beat accepted in the flush cycle is discarded.
  - The current main beat may still complete dn_xfer in the flush cycle.
  - id_pc holds its last value.
  - if_ready=1 next cycle.
- While id_valid=0, id_inst is forced to NOP_INST and id_pc holds its last value.
- Output stability: while id_valid=1 and id_ready=0, id_pc/id_inst are stable.
- Reset mid-operation: all buffered beats are dropped immediately and outputs take reset values asynchronously.
- Unused input data while if_valid=0 is ignored. No X propagates to id_inst when id_valid=0.

Decomposition:
- Shared defines file: RstEnable polarity (1'b1), ZeroWord, default InstAddrBus/InstBus widths, NOP encoding used as the NOP_INST default.
- State encoding (EMPTY/BUSY/FULL) stays local to the module.
- No sub-module. Main and skid slots are two instances of identical register logic, inline in the same module; they are not split out.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> id_valid=0, id_pc=0, id_inst=NOP_INST, if_ready=1, occupancy=0 without waiting for a clk edge.
- Streaming, id_ready=1: beats PC 0x00,0x04,0x08 on consecutive cycles -> id_pc 0x00,0x04,0x08 one cycle later each, occupancy stays 1, if_ready stays 1.
- Back-pressure: id_ready=0 after PC 0x10 is delivered, send 0x14 and 0x18 -> 0x14 is accepted into skid, occupancy=2, if_ready=0, 0x18 is held upstream. Release id_ready -> delivery order 0x10,0x14,0x18, no loss.
- Flush in FULL: occupancy=2 holding 0x20/0x24, assert flush with if_valid=1 (PC 0x28) -> next cycle id_valid=0, id_inst=NOP_INST, occupancy=0, 0x28 never appears downstream.
- Simultaneous up_xfer and dn_xfer in BUSY: main=0x30, incoming 0x34, id_ready=1 -> next cycle id_pc=0x34, occupancy=1, skid unused.
- Parameter sweep ADDR_W=64, INST_W=32, NOP_INST=32'h0000_0013: random valid/ready with flush injected 5% of the time -> scoreboard confirms in-order delivery, flush discards, and NOP_INST whenever id_valid=0.
